// File: rtl/layer_controller.sv
// layer_controller: buffers an input frame, fires the neuron array, collects results and reports the argmax
module layer_controller #(
  parameter int INPUT_SIZE  = 784,
  parameter int NUM_NEURONS = 10,
  parameter int ADDR_WIDTH  = 10,
  parameter int CLASS_WIDTH = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [15:0]                 in_data,
  input  logic                        in_last,
  output logic [16*INPUT_SIZE-1:0]    vec_out,
  output logic                        neu_start,
  input  logic [NUM_NEURONS-1:0]      neu_done,
  input  logic [16*NUM_NEURONS-1:0]   neu_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CLASS_WIDTH-1:0]      out_class,
  output logic [15:0]                 out_score,
  output logic                        err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1;
  typedef enum logic [2:0] {LOAD, DRAIN, FIRE, WAIT, ARGMAX, OUT} state_t;
  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    cnt_q, cnt_d;
  logic [NUM_NEURONS-1:0]   mask_q, mask_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     out_valid_q, out_valid_d;
  logic [CLASS_WIDTH-1:0]   out_class_q, out_class_d;
  logic [15:0]              out_score_q, out_score_d;
  logic                     err_q, err_d;
  logic [15:0]              buf_q [INPUT_SIZE];
  logic [15:0]              buf_d [INPUT_SIZE];
  logic [15:0]              res_q [NUM_NEURONS];
  logic [15:0]              res_d [NUM_NEURONS];
  logic [15:0]              cur;
  logic                     beat, last_addr;
  assign in_ready  = state_q == LOAD || state_q == DRAIN;
  assign neu_start = state_q == FIRE;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_score = out_score_q;
  assign err       = err_q;
  assign beat      = in_valid && in_ready;
  assign last_addr = cnt_q == ADDR_WIDTH'(INPUT_SIZE - 1);
  for (genvar g = 0; g < INPUT_SIZE; g++) begin : g_vec
    assign vec_out[16*g +: 16] = buf_q[g];
  end
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_score_d = out_score_q;
    err_d       = 1'b0;
    buf_d       = buf_q;
    res_d       = res_q;
    cur         = res_q[0];
    for (int i = 0; i < NUM_NEURONS; i++)
      if (idx_q == IW'(i)) cur = res_q[i];
    case (state_q)
      LOAD: if (beat) begin
        for (int i = 0; i < INPUT_SIZE; i++)
          if (cnt_q == ADDR_WIDTH'(i)) buf_d[i] = in_data;
        cnt_d   = (last_addr || in_last) ? '0 : cnt_q + 1'b1;
        err_d   = last_addr != in_last;
        state_d = last_addr ? (in_last ? FIRE : DRAIN) : LOAD;
      end
      DRAIN: state_d = (beat && in_last) ? LOAD : DRAIN;
      FIRE: begin
        mask_d  = '0;
        timer_d = '0;
        idx_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        for (int i = 0; i < NUM_NEURONS; i++)
          if (neu_done[i] && !mask_q[i]) res_d[i] = neu_result[16*i +: 16];
        mask_d  = mask_q | neu_done;
        timer_d = timer_q + 1'b1;
        if (&mask_d) state_d = ARGMAX;
        else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = LOAD;
        end
      end
      ARGMAX: begin
        if (idx_q == '0 || $signed(cur) > $signed(out_score_q)) begin
          out_class_d = CLASS_WIDTH'(idx_q);
          out_score_d = cur;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NUM_NEURONS - 1)) begin
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      mask_q      <= '0;
      timer_q     <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_score_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_score_q <= out_score_d;
      err_q       <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    res_q <= res_d;
  end
endmodule

// File: tb/tb_layer_controller.sv
// tb_layer_controller: directed self-checking bench for layer_controller
module tb_layer_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [15:0] in_data = '0;
  logic [63:0] vec_out;
  logic        neu_start;
  logic [2:0]  neu_done = '0;
  logic [47:0] neu_result = '0;
  logic        out_valid, out_ready = 1'b0, err;
  logic [1:0]  out_class;
  logic [15:0] out_score;
  int n_cmp = 0;
  int n_err = 0;
  layer_controller #(
    .INPUT_SIZE(4), .NUM_NEURONS(3), .ADDR_WIDTH(2), .CLASS_WIDTH(2), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .vec_out(vec_out), .neu_start(neu_start), .neu_done(neu_done),
    .neu_result(neu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_score(out_score), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [15:0] base, input int n, input int last_at);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = base + 16'(k);
      in_last  = k == last_at;
      tick;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask
  initial begin
    tick;
    tick;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_neu_start", neu_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_out_score", out_score, 0);
    rst = 1'b0;
    tick;
    send(16'h0001, 4, 3);
    chk("a_neu_start", neu_start, 1);
    chk("a_err", err, 0);
    chk("a_vec", vec_out, 64'h0004_0003_0002_0001);
    tick;
    chk("a_start_one_cycle", neu_start, 0);
    chk("a_wait_in_ready", in_ready, 0);
    neu_result = {16'h8000, 16'h7FFF, 16'h0100};
    neu_done = 3'b100;
    tick;
    neu_done = 3'b000;
    tick;
    neu_done = 3'b001;
    tick;
    neu_result = {16'h8000, 16'h7FFF, 16'h7FFF};
    tick;
    neu_result = {16'h8000, 16'h7FFF, 16'h0100};
    neu_done = 3'b010;
    tick;
    neu_done = 3'b000;
    chk("a_valid_d1", out_valid, 0);
    tick;
    tick;
    chk("a_valid_d3", out_valid, 0);
    tick;
    chk("a_valid_d4", out_valid, 1);
    chk("a_class", out_class, 1);
    chk("a_score", out_score, 16'h7FFF);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("hold_valid", out_valid, 1);
      chk("hold_class", out_class, 1);
      chk("hold_score", out_score, 16'h7FFF);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("acc_valid", out_valid, 0);
    chk("acc_in_ready", in_ready, 1);
    send(16'h0011, 2, 1);
    chk("short_err", err, 1);
    chk("short_no_start", neu_start, 0);
    tick;
    chk("short_err_pulse", err, 0);
    chk("short_no_start2", neu_start, 0);
    send(16'h0005, 4, 3);
    chk("b_neu_start", neu_start, 1);
    chk("b_vec", vec_out, 64'h0008_0007_0006_0005);
    tick;
    neu_result = {16'h0100, 16'h0200, 16'h0200};
    neu_done = 3'b111;
    tick;
    neu_done = 3'b000;
    tick;
    tick;
    chk("b_valid_d3", out_valid, 0);
    tick;
    chk("b_valid_d4", out_valid, 1);
    chk("b_class", out_class, 0);
    chk("b_score", out_score, 16'h0200);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("b_acc_valid", out_valid, 0);
    send(16'h0021, 4, -1);
    chk("long_err", err, 1);
    chk("long_drain_ready", in_ready, 1);
    chk("long_no_start", neu_start, 0);
    send(16'h0099, 2, 1);
    chk("drain_vec", vec_out, 64'h0024_0023_0022_0021);
    chk("drain_no_err", err, 0);
    send(16'h0001, 4, 3);
    chk("c_neu_start", neu_start, 1);
    tick;
    neu_result = {16'h0000, 16'h0003, 16'h0004};
    neu_done = 3'b011;
    tick;
    neu_done = 3'b000;
    repeat (6) tick;
    chk("to_err_early", err, 0);
    chk("to_still_wait", in_ready, 0);
    tick;
    chk("to_err", err, 1);
    chk("to_load", in_ready, 1);
    chk("to_no_valid", out_valid, 0);
    tick;
    chk("to_err_pulse", err, 0);
    send(16'h0001, 4, 3);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rw_err", err, 0);
    chk("rw_in_ready", in_ready, 1);
    chk("rw_start", neu_start, 0);
    tick;
    chk("rw_err2", err, 0);
    chk("rw_valid", out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/layer_controller.md
LAYER_CONTROLLER -- requirements
Module: layer_controller

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 784, the number of input vector elements per frame.
REQ-002 SHALL have parameter NUM_NEURONS, default 10, the number of neurons driven and scored.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, the width of the input beat counter.
REQ-004 SHALL have parameter CLASS_WIDTH, default 4, the width of the winning-index output.
REQ-005 SHALL have parameter TIMEOUT, default 1023, the maximum number of cycles spent waiting for neuron completion.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, 16, signed Q1.15) and in_last (input, 1): the input element stream.
REQ-009 SHALL have port vec_out, output, 16 x INPUT_SIZE: the buffered input vector fed to all neurons.
REQ-010 SHALL have ports neu_start (output, 1), neu_done (input, NUM_NEURONS) and neu_result (input, 16 x NUM_NEURONS, signed): the neuron handshake.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_class (output, CLASS_WIDTH) and out_score (output, 16, signed): the classification result.
REQ-012 SHALL have port err, output, 1 bit: a one-cycle pulse on a length error or a timeout.

Function
REQ-013 SHALL implement states LOAD, DRAIN, FIRE, WAIT, ARGMAX and OUT.
REQ-014 In LOAD, in_ready SHALL be 1; each in_valid&&in_ready beat SHALL write in_data to buffer[cnt] and increment cnt; in_ready SHALL be 0 in every other state except DRAIN.
REQ-015 A beat with in_last=1 at cnt==INPUT_SIZE-1 SHALL go to FIRE; cnt SHALL reset to 0.
REQ-016 A beat with in_last=1 at cnt<INPUT_SIZE-1 (short frame) SHALL pulse err, set cnt=0 and stay in LOAD; no neu_start SHALL be issued.
REQ-017 A beat at cnt==INPUT_SIZE-1 with in_last=0 (long frame) SHALL pulse err and go to DRAIN.
REQ-018 DRAIN SHALL hold in_ready=1, discard beats, and return to LOAD with cnt=0 after the in_last beat.
REQ-019 FIRE SHALL assert neu_start for exactly one cycle, clear the done mask and the timeout counter, then go to WAIT.
REQ-020 vec_out SHALL be the buffer contents, unchanged from FIRE until the next LOAD write.
REQ-021 In WAIT, neu_done[i]=1 with mask[i]=0 SHALL capture neu_result[i] and set mask[i]; repeat pulses with mask[i]=1 SHALL be ignored; several neurons SHALL be capturable in one cycle.
REQ-022 neu_done SHALL be ignored outside WAIT.
REQ-023 WAIT SHALL go to ARGMAX on the cycle after the mask becomes all ones, including completions captured in the current cycle.
REQ-024 If TIMEOUT cycles elapse in WAIT without a full mask, the block SHALL pulse err and return to LOAD; out_valid SHALL stay 0.
REQ-025 ARGMAX SHALL scan the captured results one per cycle, NUM_NEURONS cycles in total, using a signed compare and strict greater-than, so the lowest index wins a tie.
REQ-026 After the scan, out_valid SHALL rise and out_class/out_score SHALL hold the winner's index and value.
REQ-027 In OUT, out_valid, out_class and out_score SHALL stay stable until out_valid&&out_ready; the block SHALL then return to LOAD in the next cycle with out_valid=0.
REQ-028 Latency: neu_start SHALL be high in the cycle after the accepting last beat; out_valid SHALL be high NUM_NEURONS+1 cycles after the mask completes.

Reset
REQ-029 While rst=1, the state SHALL be LOAD with cnt=0, mask=0 and timer=0, and in the following cycle neu_start=0, out_valid=0, err=0, out_class=0, out_score=0 and in_ready=1.
REQ-030 The vector buffer and captured results SHALL NOT be reset.
REQ-031 A reset in any state, including mid-frame or mid-WAIT, SHALL abandon the operation without an err pulse.

Verification (INPUT_SIZE=4, NUM_NEURONS=3, TIMEOUT=8)
REQ-032 Frame 0x0001,0x0002,0x0003,0x0004 with last on beat 4 -> one-cycle neu_start on the next cycle; vec_out={1,2,3,4}; no err.
REQ-033 Results 0x0100, 0x7FFF, 0x8000 with done pulses on different cycles (neuron 2 first, then 0, then 1) -> out_valid 4 cycles after the last done; out_class=1, out_score=0x7FFF.
REQ-034 Results 0x0200, 0x0200, 0x0100 -> out_class=0, out_score=0x0200.
REQ-035 Last on beat 2 -> err for 1 cycle, no neu_start; the next 4-beat frame is processed normally.
REQ-036 Neuron 2 never done -> err exactly 8 cycles after WAIT entry, state LOAD, out_valid never 1.
REQ-037 out_ready=0 for 5 cycles after out_valid -> outputs held and in_ready=0; out_ready=1 -> accepted, in_ready=1 on the next cycle.
